// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3,
// one input bit per clock. Feeds a multiplexed 7-segment driver with packed
// BCD digits, per-digit blanking enables and a saturation flag.
//
// Handshake: an input is accepted on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, so in_valid is ignored at all other times.
// out_valid is a single-cycle pulse (the DONE cycle) marking freshly updated
// bcd_out / digit_en / ovf. There is no output back-pressure.
//
// Timing: accept edge k -> SHIFT for the cycles after edges k..k+BIN_W-1 ->
// DONE (out_valid) in the cycle after edge k+BIN_W -> IDLE after edge
// k+BIN_W+1. Counted from the accept cycle itself, out_valid is BIN_W+1
// cycles later, and one conversion completes every BIN_W+2 cycles.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  out_valid,
  output logic                  ovf,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  // Decimal value ceiling representable in DIGITS digits.
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // Scratch always holds five nibbles: enough for the full 16-bit input range
  // (65535), so the conversion never truncates even when DIGITS is smaller
  // than the input width needs. Results that do not fit DIGITS saturate.
  localparam int          SCR_D   = 5;
  localparam int          SCR_W   = 4 * SCR_D;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_DEC = 32'(pow10(DIGITS) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [BIN_W-1:0]    shreg_q;
  logic [SCR_W-1:0]    scr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_n_q;

  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   en_q;
  logic                ovf_q;

  logic                accept;
  logic                last_shift;
  logic [SCR_W-1:0]    adj;
  logic [SCR_W-1:0]    scr_next;
  logic [BIN_W-1:0]    sh_next;
  logic [4*DIGITS-1:0] res_bcd;
  logic [DIGITS-1:0]   res_en;
  logic                seen;

  assign accept     = (state_q == S_IDLE) && in_valid;
  assign last_shift = (state_q == S_SHIFT) && (cnt_q == CNT_W'(1));

  // State register; reset wins over any simultaneous in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SHIFT -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Add-3 correction: every scratch nibble >= 5 is bumped before the shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < SCR_D; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = scr_q[4*i +: 4];
      end
    end
  end

  // One-bit left shift of the {scratch, shift register} pair.
  always_comb begin
    scr_next = {adj[SCR_W-2:0], shreg_q[BIN_W-1]};
    sh_next  = shreg_q << 1;
  end

  // Result to publish on the last shift: the converted digits, or all nines
  // when the input did not fit in DIGITS decimal digits.
  always_comb begin
    if (ovf_n_q) begin
      res_bcd = {DIGITS{4'h9}};
    end else begin
      res_bcd = scr_next[4*DIGITS-1:0];
    end
  end

  // Leading-zero suppression: a digit is lit when it or any more significant
  // digit is non-zero; the ones digit is always lit so zero shows as '0'.
  always_comb begin
    seen   = 1'b0;
    res_en = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen      = seen | (res_bcd[4*i +: 4] != 4'd0);
      res_en[i] = seen;
    end
    res_en[0] = 1'b1;
  end

  // Datapath: load on accept, shift in SHIFT, publish results on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovf_n_q <= 1'b0;
      bcd_q   <= '0;
      en_q    <= DIGITS'(1);
      ovf_q   <= 1'b0;
    end else if (accept) begin
      shreg_q <= bin_in;
      scr_q   <= '0;
      cnt_q   <= CNT_W'(BIN_W);
      ovf_n_q <= (32'(bin_in) > MAX_DEC);
    end else if (state_q == S_SHIFT) begin
      shreg_q <= sh_next;
      scr_q   <= scr_next;
      cnt_q   <= cnt_q - CNT_W'(1);
      if (last_shift) begin
        bcd_q <= res_bcd;
        en_q  <= res_en;
        ovf_q <= ovf_n_q;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign bcd_out   = bcd_q;
  assign digit_en  = en_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule
